rom_loader: RTL

- Writer side of the instruction ROM's write port, which is otherwise tied off in the SoC.
- Receives a program as a byte stream over a valid/ready handshake and packs the bytes into little-endian 32-bit words.
- Drives the ROM write-enable/address/data so each word is written once.
- Holds the core in reset while a load is in progress.

---
 rtl/soc_pkg.sv | 17 +
 rtl/byte_packer.sv | 45 ++++
 rtl/rom_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared SoC constants and the ROM loader state encoding.
// Imported by the loader and its byte packer.
package soc_pkg;

    localparam int ROM_ADDR_W     = 7;
    localparam int ROM_DEPTH      = 128;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian 32-bit words.
// Ports: clk, rst (sync, active-low), i_clr, i_push, i_byte,
//        o_word (word including the byte pushed this cycle),
//        o_word_valid (this push completes a word).
module byte_packer
    import soc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [31:0]           r_word;
    logic [31:0]           w_word;

    // Look-ahead word so the caller can latch the complete word
    // on the same edge that accepts its last byte.
    always_comb begin
        w_word = r_word;
        w_word[{r_cnt, 3'b000} +: 8] = i_byte;
    end

    assign o_word       = w_word;
    assign o_word_valid = i_push &&
        (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_push) begin
            r_word <= w_word;
            r_cnt  <= r_cnt + BYTE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Loads a program byte stream into the instruction ROM write port
// and holds the core in reset while a load is in progress.
// Ports: clk, rst (sync, active-low), start_i, len_i, byte_valid_i,
//        byte_data_i, byte_ready_o, rom_wen_o, rom_w_addr_o,
//        rom_w_data_o, cpu_rst_o (active-low), busy_o, done_o.
module rom_loader
    import soc_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int DEPTH        = ROM_DEPTH,
    parameter int HOLD_AT_BOOT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              rom_wen_o,
    output logic [ADDR_W-1:0] rom_w_addr_o,
    output logic [31:0]       rom_w_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W:0] LP_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LP_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic            LP_FREE  = (HOLD_AT_BOOT == 0);

    loader_state_e     r_state;
    loader_state_e     w_state_nx;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_word_cnt;
    logic              r_boot_done;
    logic              r_ready;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic              w_accept;
    logic              w_clr;
    logic              w_last_word;
    logic              w_boot_nx;
    logic [ADDR_W:0]   w_len_clamp;
    logic [31:0]       w_word;
    logic              w_word_valid;

    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_accept    = r_ready && byte_valid_i;
    assign w_clr       = w_start || (r_state == S_WRITE);
    assign w_len_clamp = (len_i > LP_DEPTH) ? LP_DEPTH : len_i;
    assign w_last_word = ({1'b0, r_word_cnt} == (r_len - LP_ONE));
    assign w_boot_nx   = r_boot_done || (r_state == S_DONE);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_push       (w_accept),
        .i_byte       (byte_data_i),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nx = (w_len_clamp == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (w_word_valid) begin
                    w_state_nx = S_WRITE;
                end
            end
            S_WRITE: w_state_nx = w_last_word ? S_DONE : S_RECV;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so ready drops on
    // the edge that takes the 4th byte and the write strobe lands in
    // the cycle right after it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_boot_done <= 1'b0;
            r_ready     <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_cpu_rst   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_boot_done <= w_boot_nx;
            r_ready     <= (w_state_nx == S_RECV);
            r_wen       <= (w_state_nx == S_WRITE);
            r_busy      <= (w_state_nx != S_IDLE);
            r_done      <= (w_state_nx == S_DONE);
            r_cpu_rst   <= (w_state_nx == S_IDLE) &&
                           (w_boot_nx || LP_FREE);
            if (w_start) begin
                r_len      <= w_len_clamp;
                r_word_cnt <= '0;
            end else if ((r_state == S_WRITE) && !w_last_word) begin
                r_word_cnt <= r_word_cnt + ADDR_W'(1);
            end
            if (w_word_valid) begin
                r_addr <= r_word_cnt;
                r_data <= w_word;
            end
        end
    end

    assign byte_ready_o = r_ready;
    assign rom_wen_o    = r_wen;
    assign rom_w_addr_o = r_addr;
    assign rom_w_data_o = r_data;
    assign cpu_rst_o    = r_cpu_rst;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
